// File: rtl/rca_wb_drain_if.sv
// Writeback-drain bus: RCA writeback capture side, register-file write port and retire port.
// The slave modport is the drain block; the master modport is its environment.
interface rca_wb_drain_if #(
    parameter int NUM_WRITE_PORTS = 5,
    parameter int XLEN            = 32,
    parameter int ID_W            = 3
);
    logic                         wb_done;
    logic [ID_W-1:0]              wb_id;
    logic [NUM_WRITE_PORTS*XLEN-1:0] wb_rd;
    logic [NUM_WRITE_PORTS*5-1:0] wb_dest_addrs;
    logic                         wb_accept;
    logic                         rf_we;
    logic [4:0]                   rf_waddr;
    logic [XLEN-1:0]              rf_wdata;
    logic [ID_W-1:0]              rf_wid;
    logic                         rf_ack;
    logic                         retire_valid;
    logic [ID_W-1:0]              retire_id;
    logic                         busy;
    logic                         overflow_err;

    modport slave (
        input  wb_done, wb_id, wb_rd, wb_dest_addrs, rf_ack,
        output wb_accept, rf_we, rf_waddr, rf_wdata, rf_wid,
        output retire_valid, retire_id, busy, overflow_err
    );

    modport master (
        output wb_done, wb_id, wb_rd, wb_dest_addrs, rf_ack,
        input  wb_accept, rf_we, rf_waddr, rf_wdata, rf_wid,
        input  retire_valid, retire_id, busy, overflow_err
    );
endinterface

// File: rtl/rca_wb_drain.sv
// Captures one multi-result RCA writeback, serialises it onto a single register-file
// write port (valid/ack), then pulses retire for the instruction id.
module rca_wb_drain #(
    parameter int NUM_WRITE_PORTS = 5,
    parameter int XLEN            = 32,
    parameter int ID_W            = 3
) (
    input logic          clk,
    input logic          rst,
    rca_wb_drain_if.slave bus
);
    localparam int N     = NUM_WRITE_PORTS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_RETIRE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    mask_q, mask_d;
    logic [4:0]      addr_q [N];
    logic [4:0]      addr_d [N];
    logic [XLEN-1:0] data_q [N];
    logic [XLEN-1:0] data_d [N];
    logic [ID_W-1:0] id_q, id_d;
    logic [IDX_W-1:0] cur_idx_s, nxt_idx_s;

    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [ID_W-1:0] rf_wid_q, rf_wid_d;
    logic            retire_valid_q, retire_valid_d;
    logic [ID_W-1:0] retire_id_q, retire_id_d;
    logic            overflow_q, overflow_d;

    // A slot is live when its address is non-zero and no higher slot targets the same register.
    function automatic logic [N-1:0] build_mask(input logic [N*5-1:0] addrs);
        logic [N-1:0] m;
        logic [4:0]   ai;
        m = '0;
        for (int i = 0; i < N; i++) begin
            ai   = addrs[i*5 +: 5];
            m[i] = (ai != 5'd0);
            for (int j = i + 1; j < N; j++) begin
                m[i] = m[i] & (addrs[j*5 +: 5] != ai);
            end
        end
        return m;
    endfunction

    function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] m);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = m[i] ? IDX_W'(i) : idx;
        end
        return idx;
    endfunction

    assign cur_idx_s = lowest_set(mask_q);

    // Next-state, capture, drain bookkeeping and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        addr_d     = addr_q;
        data_d     = data_q;
        id_d       = id_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.wb_done) begin
                    id_d   = bus.wb_id;
                    for (int i = 0; i < N; i++) begin
                        addr_d[i] = bus.wb_dest_addrs[i*5 +: 5];
                        data_d[i] = bus.wb_rd[i*XLEN +: XLEN];
                    end
                    mask_d  = build_mask(bus.wb_dest_addrs);
                    state_d = (mask_d != '0) ? ST_DRAIN : ST_RETIRE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (bus.rf_ack) begin
                    mask_d[cur_idx_s] = 1'b0;
                    state_d = (mask_d == '0) ? ST_RETIRE : ST_DRAIN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_RETIRE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A writeback offered while busy is dropped but remembered until reset.
        if (bus.wb_done && (state_q != ST_IDLE)) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        nxt_idx_s = lowest_set(mask_d);
        rf_we_d   = (state_d == ST_DRAIN);
        if (rf_we_d) begin
            rf_waddr_d = addr_d[nxt_idx_s];
            rf_wdata_d = data_d[nxt_idx_s];
            rf_wid_d   = id_d;
        end else begin
            rf_waddr_d = rf_waddr_q;
            rf_wdata_d = rf_wdata_q;
            rf_wid_d   = rf_wid_q;
        end

        retire_valid_d = (state_d == ST_RETIRE);
        if (retire_valid_d) begin
            retire_id_d = id_d;
        end else begin
            retire_id_d = retire_id_q;
        end
    end

    // State, captured writeback and output registers; reset aborts any drain in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            mask_q         <= '0;
            id_q           <= '0;
            for (int i = 0; i < N; i++) begin
                addr_q[i] <= 5'd0;
                data_q[i] <= '0;
            end
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= 5'd0;
            rf_wdata_q     <= '0;
            rf_wid_q       <= '0;
            retire_valid_q <= 1'b0;
            retire_id_q    <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            id_q           <= id_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            rf_wid_q       <= rf_wid_d;
            retire_valid_q <= retire_valid_d;
            retire_id_q    <= retire_id_d;
            overflow_q     <= overflow_d;
        end
    end

    assign bus.wb_accept    = (state_q == ST_IDLE);
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.rf_wid       = rf_wid_q;
    assign bus.retire_valid = retire_valid_q;
    assign bus.retire_id    = retire_id_q;
    assign bus.overflow_err = overflow_q;
endmodule

// File: tb/tb_rca_wb_drain.sv
// Directed and randomized bench for rca_wb_drain; expected writes come from a
// last-writer-wins register map built per writeback.
module tb_rca_wb_drain;
    localparam int N    = 5;
    localparam int XLEN = 32;
    localparam int ID_W = 3;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    logic [4:0]      a_arr [N];
    logic [XLEN-1:0] d_arr [N];
    logic [4:0]      exp_a [$];
    logic [XLEN-1:0] exp_d [$];

    rca_wb_drain_if #(.NUM_WRITE_PORTS(N), .XLEN(XLEN), .ID_W(ID_W)) bus ();

    rca_wb_drain #(.NUM_WRITE_PORTS(N), .XLEN(XLEN), .ID_W(ID_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: for each register remember the last slot writing it; live slots drain in slot order.
    task automatic build_expect();
        int last_slot [32];
        exp_a.delete();
        exp_d.delete();
        for (int r = 0; r < 32; r++) last_slot[r] = -1;
        for (int s = 0; s < N; s++) last_slot[a_arr[s]] = s;
        for (int s = 0; s < N; s++) begin
            if (a_arr[s] != 5'd0 && last_slot[a_arr[s]] == s) begin
                exp_a.push_back(a_arr[s]);
                exp_d.push_back(d_arr[s]);
            end
        end
    endtask

    task automatic start_wb(input logic [ID_W-1:0] id);
        build_expect();
        chk("accept_before_wb", bus.wb_accept, 1);
        chk("busy_before_wb", bus.busy, 0);
        bus.wb_done = 1'b1;
        bus.wb_id   = id;
        for (int s = 0; s < N; s++) begin
            bus.wb_dest_addrs[s*5 +: 5]   = a_arr[s];
            bus.wb_rd[s*XLEN +: XLEN]     = d_arr[s];
        end
        bus.rf_ack = 1'b0;
        step();
        bus.wb_done       = 1'b0;
        bus.wb_id         = ID_W'($urandom);
        bus.wb_rd         = {$urandom, $urandom, $urandom, $urandom, $urandom};
        bus.wb_dest_addrs = 25'($urandom);
    endtask

    task automatic finish_wb(input logic [ID_W-1:0] id, input bit rand_ack);
        int cyc;
        bit ack;
        cyc = 0;
        while (exp_a.size() > 0 && cyc < 200) begin
            chk("rf_we", bus.rf_we, 1);
            chk("rf_waddr", bus.rf_waddr, exp_a[0]);
            chk("rf_wdata", bus.rf_wdata, exp_d[0]);
            chk("rf_wid", bus.rf_wid, id);
            chk("retire_early", bus.retire_valid, 0);
            chk("busy_drain", bus.busy, 1);
            ack = rand_ack ? bit'($urandom_range(0, 1)) : 1'b1;
            bus.rf_ack = ack;
            step();
            cyc++;
            if (ack) begin
                void'(exp_a.pop_front());
                void'(exp_d.pop_front());
            end
        end
        bus.rf_ack = 1'b0;
        chk("drain_bound", (cyc < 200), 1);
        chk("rf_we_after_drain", bus.rf_we, 0);
        chk("retire_valid", bus.retire_valid, 1);
        chk("retire_id", bus.retire_id, id);
        chk("busy_retire", bus.busy, 1);
        step();
        chk("retire_one_cycle", bus.retire_valid, 0);
        chk("accept_after_retire", bus.wb_accept, 1);
        chk("rf_we_idle", bus.rf_we, 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_rf_we", bus.rf_we, 0);
        chk("rst_rf_waddr", bus.rf_waddr, 0);
        chk("rst_rf_wdata", bus.rf_wdata, 0);
        chk("rst_rf_wid", bus.rf_wid, 0);
        chk("rst_retire_valid", bus.retire_valid, 0);
        chk("rst_retire_id", bus.retire_id, 0);
        chk("rst_overflow", bus.overflow_err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_accept", bus.wb_accept, 1);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus.wb_done   = 1'b0;
        bus.wb_id     = '0;
        bus.wb_rd     = '0;
        bus.wb_dest_addrs = '0;
        bus.rf_ack    = 1'b0;
        repeat (3) step();
        chk_reset_vals();
        rst = 1'b0;
        step();
        chk_reset_vals();

        // 1: single live slot
        for (int s = 0; s < N; s++) begin a_arr[s] = 5'd0; d_arr[s] = 32'h0; end
        a_arr[1] = 5'd7; d_arr[1] = 32'h0000_DEAD;
        start_wb(3'd2);
        finish_wb(3'd2, 1'b0);

        // 2: five distinct writes
        for (int s = 0; s < N; s++) begin a_arr[s] = 5'(s + 1); d_arr[s] = 32'(16 + s); end
        start_wb(3'd5);
        finish_wb(3'd5, 1'b0);

        // 3: no writes at all
        for (int s = 0; s < N; s++) begin a_arr[s] = 5'd0; d_arr[s] = $urandom; end
        start_wb(3'd3);
        finish_wb(3'd3, 1'b0);

        // 4: duplicate destination, highest slot wins
        for (int s = 0; s < N; s++) begin a_arr[s] = 5'd0; d_arr[s] = 32'h0; end
        a_arr[1] = 5'd9; d_arr[1] = 32'hA;
        a_arr[3] = 5'd9; d_arr[3] = 32'hB;
        start_wb(3'd1);
        chk("dup_single_write", exp_a.size(), 1);
        finish_wb(3'd1, 1'b0);

        // 5: stalled ack, dropped overlapping writeback
        for (int s = 0; s < N; s++) begin a_arr[s] = 5'(11 + s); d_arr[s] = $urandom; end
        chk("overflow_clear", bus.overflow_err, 0);
        start_wb(3'd6);
        for (int c = 0; c < 4; c++) begin
            chk("stall_rf_we", bus.rf_we, 1);
            chk("stall_waddr", bus.rf_waddr, exp_a[0]);
            chk("stall_wdata", bus.rf_wdata, exp_d[0]);
            chk("stall_wid", bus.rf_wid, 3'd6);
            chk("stall_overflow", bus.overflow_err, (c >= 2) ? 1 : 0);
            bus.rf_ack        = 1'b0;
            bus.wb_done       = (c == 1);
            bus.wb_dest_addrs = {5'd20, 5'd21, 5'd22, 5'd23, 5'd24};
            step();
        end
        bus.wb_done = 1'b0;
        finish_wb(3'd6, 1'b0);
        chk("overflow_sticky", bus.overflow_err, 1);

        // 6: reset in the middle of a drain
        for (int s = 0; s < N; s++) begin a_arr[s] = 5'(26 + s); d_arr[s] = $urandom; end
        start_wb(3'd4);
        for (int c = 0; c < 2; c++) begin
            chk("pre_rst_waddr", bus.rf_waddr, exp_a[0]);
            chk("pre_rst_wdata", bus.rf_wdata, exp_d[0]);
            bus.rf_ack = 1'b1;
            step();
            void'(exp_a.pop_front());
            void'(exp_d.pop_front());
        end
        rst        = 1'b1;
        bus.rf_ack = 1'b0;
        step();
        chk_reset_vals();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("post_rst_rf_we", bus.rf_we, 0);
            chk("post_rst_retire", bus.retire_valid, 0);
            step();
        end
        for (int s = 0; s < N; s++) begin a_arr[s] = 5'(3 + s); d_arr[s] = $urandom; end
        start_wb(3'd7);
        finish_wb(3'd7, 1'b0);

        // Random writebacks with dense register collisions and random ack stalls
        for (int t = 0; t < 40; t++) begin
            logic [ID_W-1:0] rid;
            for (int s = 0; s < N; s++) begin
                a_arr[s] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 8));
                d_arr[s] = $urandom;
            end
            rid = ID_W'($urandom);
            start_wb(rid);
            finish_wb(rid, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
